uart8_flow_tx: RTL and testbench

Single-clock 8N1 UART transmitter with hardware flow control, fed from a valid/ready byte stream through an internal FIFO.
It is the host-side sender that drives the bridge's RXD line and obeys the bridge's RTS output, which it receives on its own CTS input (active-low).
It contains its own baud divider, so no external baud clock is needed.

---
 rtl/uart8_flow_tx.sv | 183 ++++++++++++++++++
 tb/tb_uart8_flow_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart8_flow_tx.sv
// 8N1 UART transmitter with an internal byte FIFO, active-low CTS flow control
// and a built-in baud divider; CTS and en only gate the launch of new frames.
module uart8_flow_tx #(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          CTS,
  output logic                          TXD,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          isFifoEmpty,
  output logic                          isFifoFull
);

  localparam int DIVISOR = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W   = $clog2(DIVISOR);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic             stop_idx, stop_idx_n;
  logic [7:0]       shreg, shreg_n;

  logic             cts_meta, cts_s;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop, launch, baud_last, stop_last;

  // CTS is asynchronous to clk; both flops reset to "not clear"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
    end else begin
      cts_meta <= CTS;
      cts_s    <= cts_meta;
    end
  end

  assign isFifoEmpty = (count == '0);
  assign isFifoFull  = (count == CNT_FULL);
  assign in_ready    = !isFifoFull;
  assign fifo_count  = count;
  assign push        = in_valid && in_ready;
  assign launch      = !isFifoEmpty && en && !cts_s;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Occupancy is tracked separately from the wrapping pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      shreg    <= shreg_n;
    end
  end

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign stop_last = (STOP_BITS == 2) ? stop_idx : 1'b1;

  // Baud counter restarts on every state entry, so each bit lasts DIVISOR cycles
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shreg_n    = shreg;
    pop        = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (launch) begin
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
          state_n = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          shreg_n    = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            stop_idx_n = 1'b0;
            state_n    = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_n = baud_cnt + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_cnt_n = '0;
          if (stop_last) begin
            done = 1'b1;
            // Chain straight into the next frame when one is ready
            if (launch) begin
              pop     = 1'b1;
              shreg_n = mem[rd_ptr];
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            stop_idx_n = 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + BAUD_ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    TXD  = 1'b1;
    busy = 1'b1;
    unique case (state)
      IDLE:    busy = 1'b0;
      START:   TXD  = 1'b0;
      DATA:    TXD  = shreg[0];
      STOP:    TXD  = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart8_flow_tx.sv
// Directed bench for uart8_flow_tx with DIVISOR=16: one instance with one stop
// bit and one with two, checked bit period by bit period against expected frames.
module tb_uart8_flow_tx;

  logic       clk, rst_n;
  logic       en1, in_valid1, cts1, en2, in_valid2, cts2;
  logic [7:0] in_data1, in_data2;
  logic       in_ready1, txd1, busy1, done1, empty1, full1;
  logic       in_ready2, txd2, busy2, done2, empty2, full2;
  logic [3:0] count1, count2;

  int tests = 0;
  int failures = 0;

  uart8_flow_tx #(.CLOCK_RATE(16), .BAUD_RATE(1), .FIFO_DEPTH(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .CTS(cts1), .TXD(txd1), .busy(busy1), .done(done1),
    .fifo_count(count1), .isFifoEmpty(empty1), .isFifoFull(full1)
  );

  uart8_flow_tx #(.CLOCK_RATE(16), .BAUD_RATE(1), .FIFO_DEPTH(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .CTS(cts2), .TXD(txd2), .busy(busy2), .done(done2),
    .fifo_count(count2), .isFifoEmpty(empty2), .isFifoFull(full2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic txd_of(input bit which);
    return which ? txd2 : txd1;
  endfunction

  // One-cycle push, starting at a negedge and returning at the next negedge
  task automatic applyStimulus(input bit which, input logic [7:0] d);
    if (which) begin
      in_data2  = d;
      in_valid2 = 1'b1;
    end else begin
      in_data1  = d;
      in_valid1 = 1'b1;
    end
    @(negedge clk);
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic waitStart(input bit which, input int max, output bit found, output int waited);
    found  = 1'b0;
    waited = 0;
    while (!found && waited < max) begin
      if (txd_of(which) == 1'b0) found = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
  endtask

  // Entered at the negedge of the first START cycle; leaves one cycle past the frame
  task automatic expectFrame(input string tag, input bit which, input logic [7:0] b);
    int         nbits;
    int         cyc;
    int         busy_cnt;
    int         done_cnt;
    int         done_pos;
    logic [15:0] vec;
    logic       exp_bit;
    nbits    = which ? 11 : 10;
    cyc      = 0;
    busy_cnt = 0;
    done_cnt = 0;
    done_pos = -1;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0)      exp_bit = 1'b0;
      else if (i <= 8) exp_bit = b[i-1];
      else             exp_bit = 1'b1;
      for (int c = 0; c < 16; c++) begin
        vec[c] = txd_of(which);
        if (which ? busy2 : busy1) busy_cnt++;
        if (which ? done2 : done1) begin
          done_cnt++;
          done_pos = cyc;
        end
        cyc++;
        @(negedge clk);
      end
      checkOutput($sformatf("%s bit%0d", tag, i), 32'(vec), exp_bit ? 32'h0000FFFF : 32'h0);
    end
    checkOutput($sformatf("%s busy cycles", tag), busy_cnt, nbits * 16);
    checkOutput($sformatf("%s done count", tag), done_cnt, 1);
    checkOutput($sformatf("%s done position", tag), done_pos, nbits * 16 - 1);
  endtask

  logic [7:0] burst [8] = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h96, 8'h69};

  initial begin
    bit found;
    int waited;
    rst_n = 1'b0;
    en1 = 1'b1; cts1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0;
    en2 = 1'b0; cts2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;

    @(negedge clk);
    checkOutput("reset TXD", txd1, 1);
    checkOutput("reset busy", busy1, 0);
    checkOutput("reset done", done1, 0);
    checkOutput("reset count", count1, 0);
    checkOutput("reset empty", empty1, 1);
    checkOutput("reset full", full1, 0);
    checkOutput("reset in_ready", in_ready1, 1);
    checkOutput("reset TXD stop2", txd2, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: start bit two cycles after the push
    applyStimulus(0, 8'hA5);
    checkOutput("A5 idle after push", txd1, 1);
    @(negedge clk);
    checkOutput("A5 start latency", txd1, 0);
    expectFrame("A5", 0, 8'hA5);
    checkOutput("A5 idle after", busy1, 0);
    repeat (3) @(negedge clk);

    // Three frames back to back with no idle gap
    fork
      begin
        applyStimulus(0, 8'h00);
        applyStimulus(0, 8'hFF);
        applyStimulus(0, 8'h3C);
      end
      begin
        waitStart(0, 10, found, waited);
        checkOutput("b2b start found", found, 1);
        expectFrame("b2b 00", 0, 8'h00);
        expectFrame("b2b FF", 0, 8'hFF);
        expectFrame("b2b 3C", 0, 8'h3C);
      end
    join
    checkOutput("b2b count drained", count1, 0);
    checkOutput("b2b busy after", busy1, 0);

    // Flow-controlled fill: CTS high blocks, FIFO fills, ninth byte is dropped
    cts1 = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) applyStimulus(0, burst[i]);
    checkOutput("fill count", count1, 8);
    checkOutput("fill full", full1, 1);
    checkOutput("fill in_ready", in_ready1, 0);
    applyStimulus(0, 8'hEE);
    checkOutput("fill ninth ignored", count1, 8);
    checkOutput("fill TXD held", txd1, 1);
    cts1 = 1'b0;
    @(negedge clk);
    checkOutput("cts release +1", txd1, 1);
    @(negedge clk);
    checkOutput("cts release +2", txd1, 1);
    @(negedge clk);
    checkOutput("cts release +3 start", txd1, 0);
    for (int i = 0; i < 8; i++) expectFrame($sformatf("burst%0d", i), 0, burst[i]);
    waitStart(0, 100, found, waited);
    checkOutput("no frame for dropped byte", found, 0);
    checkOutput("burst count drained", count1, 0);

    // CTS raised mid-frame: current frame completes, next one is held
    fork
      begin
        applyStimulus(0, 8'h81);
        applyStimulus(0, 8'h42);
      end
      begin
        waitStart(0, 10, found, waited);
        checkOutput("midcts start found", found, 1);
        fork
          expectFrame("midcts 81", 0, 8'h81);
          begin
            repeat (60) @(negedge clk);
            cts1 = 1'b1;
          end
        join
      end
    join
    waitStart(0, 200, found, waited);
    checkOutput("midcts blocked", found, 0);
    checkOutput("midcts count kept", count1, 1);
    cts1 = 1'b0;
    waitStart(0, 10, found, waited);
    checkOutput("midcts resume", found, 1);
    expectFrame("midcts 42", 0, 8'h42);

    // Asynchronous reset in the middle of a frame
    fork
      begin
        applyStimulus(0, 8'h00);
        applyStimulus(0, 8'h00);
      end
      begin
        waitStart(0, 10, found, waited);
        checkOutput("rst start found", found, 1);
        repeat (50) @(negedge clk);
      end
    join
    checkOutput("rst pre TXD low", txd1, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("rst async TXD", txd1, 1);
    checkOutput("rst async busy", busy1, 0);
    checkOutput("rst async count", count1, 0);
    checkOutput("rst async empty", empty1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    waitStart(0, 200, found, waited);
    checkOutput("rst no spurious frame", found, 0);
    fork
      applyStimulus(0, 8'h5A);
      begin
        waitStart(0, 10, found, waited);
        checkOutput("rst new start", found, 1);
        expectFrame("post-rst 5A", 0, 8'h5A);
      end
    join

    // Two stop bits, launch held off by en
    applyStimulus(1, 8'hC3);
    waitStart(1, 50, found, waited);
    checkOutput("en0 no launch", found, 0);
    checkOutput("en0 count", count2, 1);
    en2 = 1'b1;
    waitStart(1, 5, found, waited);
    checkOutput("en1 launch", found, 1);
    checkOutput("en1 latency", waited, 1);
    expectFrame("stop2 C3", 1, 8'hC3);
    checkOutput("stop2 idle after", busy2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
